// File: rtl/vga_timing_rx.sv
// Receive-side VGA sync decoder: checks hs/vs against a fixed raster timing,
// regenerates de/x/y once locked, and reports timing violations.
module vga_timing_rx #(
    parameter int H_ACTIVE    = 1024,
    parameter int H_SYNC      = 136,
    parameter int H_BACK      = 160,
    parameter int H_TOTAL     = 1344,
    parameter int V_ACTIVE    = 768,
    parameter int V_SYNC      = 6,
    parameter int V_BACK      = 29,
    parameter int V_TOTAL     = 806,
    parameter bit SYNC_NEG    = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    output logic        locked,
    output logic        de,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        frame_start,
    output logic        err,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;

    localparam logic [11:0] H_TOT_C  = 12'(H_TOTAL);
    localparam logic [11:0] H_SYNC_C = 12'(H_SYNC);
    localparam logic [11:0] H_TO_C   = 12'(2 * H_TOTAL);
    localparam logic [11:0] H_BEG_C  = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_END_C  = 12'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] X_OFS_C  = 11'(H_SYNC + H_BACK);
    localparam logic [9:0]  V_TOT_C  = 10'(V_TOTAL);
    localparam logic [9:0]  V_SYNC_C = 10'(V_SYNC);
    localparam logic [9:0]  V_BEG_C  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_END_C  = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [3:0]  LOCK_C   = 4'(LOCK_FRAMES);

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]  s_q, s_qq;       // {vs, hs}, normalised to active-high
    logic        hs_lead, hs_trail, vs_lead, vs_trail;
    logic [11:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        h_armed;
    state_t      state_q, state_d;
    logic [3:0]  clean_q, clean_d;
    logic        chk_fail, err_any, active;

    // Stage 0: polarity normalisation and edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q  <= '0;
            s_qq <= '0;
        end else begin
            s_q  <= {vs, hs} ^ {2{SYNC_NEG}};
            s_qq <= s_q;
        end
    end

    assign hs_lead  =  s_q[0] & ~s_qq[0];
    assign hs_trail = ~s_q[0] &  s_qq[0];
    assign vs_lead  =  s_q[1] & ~s_qq[1];
    assign vs_trail = ~s_q[1] &  s_qq[1];

    // Stage 1: line/frame counters; h_armed suppresses the line-length check
    // until a reference hs edge has been seen outside SEARCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            h_armed <= 1'b0;
        end else begin
            h_cnt <= hs_lead ? 12'd0 : sat_inc12(h_cnt);
            if (vs_lead)
                v_cnt <= '0;
            else if (hs_lead)
                v_cnt <= v_cnt + 10'd1;
            if (state_q == SEARCH)
                h_armed <= 1'b0;
            else if (hs_lead)
                h_armed <= 1'b1;
        end
    end

    always_comb begin
        chk_fail = 1'b0;
        if (hs_lead && h_armed && (h_cnt + 12'd1 != H_TOT_C))
            chk_fail = 1'b1;
        if (hs_trail && (h_cnt + 12'd1 != H_SYNC_C))
            chk_fail = 1'b1;
        if (vs_lead && (v_cnt + 10'd1 != V_TOT_C))
            chk_fail = 1'b1;
        if (vs_trail && (v_cnt + {9'd0, hs_lead} != V_SYNC_C))
            chk_fail = 1'b1;
        if (!hs_lead && (h_cnt + 12'd1 == H_TO_C))
            chk_fail = 1'b1;
        err_any = chk_fail && (state_q != SEARCH);
    end

    always_comb begin
        state_d = state_q;
        clean_d = clean_q;
        case (state_q)
            SEARCH: begin
                if (vs_lead) begin
                    state_d = TRAIN;
                    clean_d = '0;
                end
            end
            TRAIN: begin
                if (err_any)
                    clean_d = '0;
                else if (vs_lead) begin
                    if (clean_q + 4'd1 >= LOCK_C)
                        state_d = LOCKED;
                    else
                        clean_d = clean_q + 4'd1;
                end
            end
            LOCKED: begin
                if (err_any)
                    state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
            clean_q <= '0;
        end else begin
            state_q <= state_d;
            clean_q <= clean_d;
        end
    end

    assign active = (state_q == LOCKED) &&
                    (h_cnt >= H_BEG_C) && (h_cnt < H_END_C) &&
                    (v_cnt >= V_BEG_C) && (v_cnt < V_END_C);

    // Stage 2: registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked      <= 1'b0;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            err_cnt     <= '0;
        end else begin
            locked      <= (state_q == LOCKED);
            de          <= active;
            x           <= active ? h_cnt[10:0] - X_OFS_C : '0;
            y           <= active ? v_cnt - V_BEG_C : '0;
            frame_start <= (state_q == LOCKED) && vs_lead;
            err         <= err_any;
            if ((state_q == LOCKED) && err_any)
                err_cnt <= sat_inc16(err_cnt);
        end
    end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx using a scaled-down raster
// (32 clocks x 16 lines, 16x8 active) so several frames fit in a short run.
module tb_vga_timing_rx;

    localparam int H_SYNC_T = 4;
    localparam int H_TOT_T  = 32;
    localparam int V_TOT_T  = 16;

    logic        clk = 1'b0;
    logic        rst, hs, vs;
    logic        locked, de, frame_start, err;
    logic [10:0] x;
    logic [9:0]  y;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    vga_timing_rx #(
        .H_ACTIVE(16), .H_SYNC(H_SYNC_T), .H_BACK(6), .H_TOTAL(H_TOT_T),
        .V_ACTIVE(8), .V_SYNC(2), .V_BACK(3), .V_TOTAL(V_TOT_T),
        .SYNC_NEG(1'b1), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs),
        .locked(locked), .de(de), .x(x), .y(y),
        .frame_start(frame_start), .err(err), .err_cnt(err_cnt)
    );

    int cyc = 0, checks = 0, errors = 0;
    int hc, vc, vsw, long_vc, frame_drv, line_drv;
    bit hold, lk_prev;
    int err_n, de_n, fs_n, err_edge, fs_edge, lk_rise, lk_fall, de_first;
    int xy_bad, ex, ey;
    int n0, ld, r0, f5, r1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        err_n = 0; de_n = 0; fs_n = 0;
        err_edge = -1; fs_edge = -1; lk_rise = -1; lk_fall = -1; de_first = -1;
    endtask

    // One clock: observe outputs just after the edge, then drive the next sync sample.
    task automatic step();
        int len;
        @(posedge clk);
        cyc++;
        #1;
        err_n += int'(err);
        fs_n  += int'(frame_start);
        if (err === 1'b1 && err_edge < 0) err_edge = cyc;
        if (frame_start === 1'b1 && fs_edge < 0) fs_edge = cyc;
        if (locked === 1'b1 && !lk_prev) lk_rise = cyc;
        if (locked !== 1'b1 && lk_prev) lk_fall = cyc;
        lk_prev = (locked === 1'b1);
        if (de === 1'b1) begin
            de_n++;
            if (de_first < 0) de_first = cyc;
            if (x !== 11'(ex) || y !== 10'(ey)) xy_bad++;
            ex++;
            if (ex == 16) begin
                ex = 0;
                ey = (ey == 7) ? 0 : ey + 1;
            end
        end else if (x !== 11'd0 || y !== 10'd0) begin
            xy_bad++;
        end
        if (locked !== 1'b1) begin
            ex = 0;
            ey = 0;
        end
        if (hold) begin
            hs = 1'b1;
            vs = 1'b1;
        end else begin
            if (hc == 0 && vc == 0) frame_drv = cyc;
            if (hc == 0) line_drv = cyc;
            hs = (hc < H_SYNC_T) ? 1'b0 : 1'b1;
            vs = (vc < vsw) ? 1'b0 : 1'b1;
            len = (vc == long_vc) ? H_TOT_T + 1 : H_TOT_T;
            hc++;
            if (hc == len) begin
                if (vc == long_vc) long_vc = -1;
                hc = 0;
                vc = (vc == V_TOT_T - 1) ? 0 : vc + 1;
            end
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        rst = 1'b1; hs = 1'b1; vs = 1'b1; hold = 1'b1;
        hc = 0; vc = 0; vsw = 2; long_vc = -1;
        xy_bad = 0; ex = 0; ey = 0; lk_prev = 1'b0;
        frame_drv = 0; line_drv = 0;
        clear_mon();
        repeat (3) step();
        chk("rst_locked", locked, 0);
        chk("rst_de", de, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // Nominal stream: lock on 3rd vs_lead, full active frames after.
        rst = 1'b0; hold = 1'b0; hc = 0; vc = 0;
        clear_mon();
        step();
        n0 = frame_drv;
        run_to(n0 + 1536);
        chk("lock_rise_edge", lk_rise, n0 + 1027);
        chk("first_de_edge", de_first, n0 + 1197);
        chk("de_count_frame3", de_n, 128);
        run_to(n0 + 2047);
        chk("de_count_frame4", de_n, 256);
        chk("frame_start_count", fs_n, 1);
        chk("frame_start_edge", fs_edge, n0 + 1538);
        chk("nominal_err_pulses", err_n, 0);
        chk("nominal_err_cnt", err_cnt, 0);

        // One line lengthened by a clock while locked.
        long_vc = 8;
        clear_mon();
        run_to(n0 + 3600);
        chk("longline_err_edge", err_edge, n0 + 2339);
        chk("longline_err_pulses", err_n, 1);
        chk("longline_lock_fall", lk_fall, n0 + 2340);
        chk("longline_err_cnt", err_cnt, 1);
        chk("longline_relock_edge", lk_rise, n0 + 3588);
        chk("longline_locked", locked, 1);

        // hs stops after line 5 of a locked frame.
        for (int i = 0; i < 600 && !(hc == 0 && vc == 6); i++) step();
        ld = line_drv;
        hold = 1'b1;
        clear_mon();
        repeat (100) step();
        chk("timeout_err_edge", err_edge, ld + 66);
        chk("timeout_err_pulses", err_n, 1);
        chk("timeout_err_cnt", err_cnt, 2);
        chk("timeout_lock_fall", lk_fall, ld + 67);
        chk("timeout_locked", locked, 0);

        hold = 1'b0; hc = 0; vc = 0;
        clear_mon();
        step();
        r0 = frame_drv;
        run_to(r0 + 1100);
        chk("resume_relock_edge", lk_rise, r0 + 1027);
        chk("resume_err_pulses", err_n, 0);

        // vs pulse one line short while locked.
        for (int i = 0; i < 600 && !(hc == 0 && vc == 0); i++) step();
        vsw = 1;
        clear_mon();
        step();
        f5 = frame_drv;
        repeat (79) step();
        vsw = 2;
        repeat (20) step();
        chk("shortvs_frame_start_edge", fs_edge, f5 + 2);
        chk("shortvs_err_edge", err_edge, f5 + 34);
        chk("shortvs_err_pulses", err_n, 1);
        chk("shortvs_err_cnt", err_cnt, 3);
        chk("shortvs_lock_fall", lk_fall, f5 + 35);
        chk("shortvs_locked", locked, 0);

        // Asynchronous reset in the middle of an active line.
        run_to(f5 + 1600);
        chk("pre_reset_locked", locked, 1);
        for (int i = 0; i < 700 && !(de === 1'b1 && x == 11'd5); i++) step();
        chk("pre_reset_de", de, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_locked", locked, 0);
        chk("async_de", de, 0);
        chk("async_x", x, 0);
        chk("async_err_cnt", err_cnt, 0);
        hold = 1'b1;
        repeat (3) step();
        chk("held_reset_locked", locked, 0);
        rst = 1'b0; hold = 1'b0; hc = 0; vc = 0;
        clear_mon();
        step();
        r1 = frame_drv;
        run_to(r1 + 1100);
        chk("post_reset_relock_edge", lk_rise, r1 + 1027);
        chk("post_reset_err_pulses", err_n, 0);
        chk("post_reset_err_cnt", err_cnt, 0);
        chk("xy_sequence_errors", xy_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
